// File: rtl/ff_chk_pkg.sv
// Shared state encoding and failure-kind codes for the flop response checker.
// Pure definitions: no latency, no flow control.
// Backpressure: not applicable.
package ff_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_Q    = 2'b01;
  localparam logic [1:0] ERR_QN   = 2'b10;
  localparam logic [1:0] ERR_BOTH = 2'b11;

  function automatic logic [1:0] err_code(input logic q_bad, input logic qn_bad);
    logic [1:0] code;
    case ({qn_bad, q_bad})
      2'b01:   code = ERR_Q;
      2'b10:   code = ERR_QN;
      2'b11:   code = ERR_BOTH;
      default: code = ERR_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/ff_ref_model.sv
// Golden D flop with enable and reset, tracking whether its value is known yet.
// Latency: one cycle from sampled stimulus to exp_q/exp_vld.
// Backpressure: none; updates whenever upd is high.
module ff_ref_model (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic upd,
  input  logic obs_rst_n,
  input  logic obs_clk_en,
  input  logic obs_d,
  output logic exp_q,
  output logic exp_vld
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q   <= 1'b0;
      exp_vld <= 1'b0;
    end else if (clr) begin
      exp_q   <= 1'b0;
      exp_vld <= 1'b0;
    end else if (upd) begin
      // Flop reset dominates the enable, as in the observed flop.
      if (!obs_rst_n) begin
        exp_q   <= 1'b0;
        exp_vld <= 1'b1;
      end else if (obs_clk_en) begin
        exp_q   <= obs_d;
        exp_vld <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ff_resp_checker.sv
// Compares an observed flop's q/q_ against a golden model over a window of cycles.
// Latency: pass/fail registered on the final checked edge; all outputs registered.
// Backpressure: none; start during a run is ignored, clear always wins.
module ff_resp_checker
  import ff_chk_pkg::*;
#(
  parameter int WINDOW      = 32,
  parameter int CNT_W       = 8,
  parameter int CYC_W       = 16,
  parameter int STOP_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             obs_clk_en,
  input  logic             obs_rst_n,
  input  logic             obs_d,
  input  logic             obs_q,
  input  logic             obs_qn,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] err_count,
  output logic [CYC_W-1:0] first_err_cycle,
  output logic [1:0]       first_err_code,
  output logic [CYC_W-1:0] cycle_count
);

  state_t     state;
  logic       in_check;
  logic       launch;
  logic       exp_q;
  logic       exp_vld;
  logic       exp_now;
  logic       q_bad;
  logic       qn_bad;
  logic       mism;
  logic       run_end;
  logic [CNT_W-1:0] err_inc;

  assign in_check = (state == CHECK);
  assign launch   = start && !clear && !in_check;

  ff_ref_model u_ref (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (launch || clear),
    .upd        (in_check),
    .obs_rst_n  (obs_rst_n),
    .obs_clk_en (obs_clk_en),
    .obs_d      (obs_d),
    .exp_q      (exp_q),
    .exp_vld    (exp_vld)
  );

  // q is only comparable once the model holds a known value, or while reset forces it.
  assign exp_now = obs_rst_n ? exp_q : 1'b0;
  assign q_bad   = (exp_vld || !obs_rst_n) && (obs_q != exp_now);
  assign qn_bad  = (obs_qn != ~obs_q);
  assign mism    = in_check && (q_bad || qn_bad);
  assign run_end = in_check &&
                   ((cycle_count == CYC_W'(WINDOW - 1)) || ((STOP_ON_ERR != 0) && mism));
  assign err_inc = (err_count == {CNT_W{1'b1}}) ? err_count : err_count + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      busy            <= 1'b0;
      pass            <= 1'b0;
      fail            <= 1'b0;
      err_count       <= '0;
      first_err_cycle <= '0;
      first_err_code  <= ERR_NONE;
      cycle_count     <= '0;
    end else if (clear) begin
      state           <= IDLE;
      busy            <= 1'b0;
      pass            <= 1'b0;
      fail            <= 1'b0;
      err_count       <= '0;
      first_err_cycle <= '0;
      first_err_code  <= ERR_NONE;
      cycle_count     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state           <= CHECK;
            busy            <= 1'b1;
            pass            <= 1'b0;
            fail            <= 1'b0;
            err_count       <= '0;
            first_err_cycle <= '0;
            first_err_code  <= ERR_NONE;
            cycle_count     <= '0;
          end
        end
        CHECK: begin
          cycle_count <= cycle_count + CYC_W'(1);
          if (mism) begin
            err_count <= err_inc;
            // err_count saturates rather than wraps, so zero means no earlier mismatch.
            if (err_count == '0) begin
              first_err_code  <= err_code(q_bad, qn_bad);
              first_err_cycle <= cycle_count;
            end
          end
          if (run_end) begin
            state <= DONE;
            busy  <= 1'b0;
            pass  <= (err_count == '0) && !mism;
            fail  <= (err_count != '0) || mism;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ff_resp_checker.md
Name: ff_resp_checker

Overview:
- Synthesizable response checker for a single-bit D flip-flop with clock enable, async active-low reset and complementary outputs. It observes the flop's stimulus and outputs and raises pass/fail.
- Reader/checker end of the flop-stimulus interface. It sits beside the flop (bench or on-chip BIST) and compares observed q/q_ against a golden model every cycle over a programmable window.
- Reports error count, first-failure cycle and failure kind.

Parameters:
- WINDOW, 32: number of checked cycles per run (≥2).
- CNT_W, 8: width of err_count (saturating).
- CYC_W, 16: width of cycle_count/first_err_cycle; must satisfy 2^CYC_W > WINDOW.
- STOP_ON_ERR, 0: 1 = end run at first mismatch; 0 = run full window.

Ports:
- clk  in  1  shared clock with observed flop; all sampling on rising edge.
- rst_n  in  1  checker reset; asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- clear  in  1  one-cycle pulse; returns to IDLE, zeroes all results.
- obs_clk_en  in  1  clock enable as driven to the flop.
- obs_rst_n  in  1  flop reset as driven to the flop (async, active-low).
- obs_d  in  1  flop data input as driven.
- obs_q  in  1  flop q output.
- obs_qn  in  1  flop q_ output.
- busy  out  1  high in CHECK.
- pass  out  1  high in DONE with err_count==0.
- fail  out  1  high in DONE with err_count!=0.
- err_count  out  CNT_W  mismatching cycles, saturates at all-ones.
- first_err_cycle  out  CYC_W  cycle_count value of first mismatch.
- first_err_code  out  2  01 q wrong, 10 q_ not ~q, 11 both, 00 none.
- cycle_count  out  CYC_W  checked cycles in current/last run.

Behaviour:
- rst_n low (async): state IDLE; all outputs 0; model exp_q=0, exp_vld=0.
- States:
  - IDLE: start goes to CHECK.
  - CHECK: terminal count or stop-on-error goes to DONE.
  - DONE: start goes to CHECK; clear goes to IDLE.
  - clear in any state goes to IDLE and wins over start in the same cycle.
- Entry to CHECK (edge where start sampled):
  - err_count, first_err_code, first_err_cycle and cycle_count zeroed.
  - exp_vld=0.
  - busy=1 from the next cycle.
- Each rising edge in CHECK, using inputs sampled at that edge:
  - exp_now = 0 if obs_rst_n==0, else exp_q.
  - q check applies only when exp_vld==1 or obs_rst_n==0: mismatch if obs_q != exp_now.
  - qn check always applies: mismatch if obs_qn != ~obs_q.
  - Model update:
    - obs_rst_n==0: exp_q←0, exp_vld←1.
    - else obs_clk_en==1: exp_q←obs_d, exp_vld←1.
    - else: exp_q and exp_vld hold.
  - Any mismatch:
    - err_count+1 (saturating).
    - If this is the first mismatch of the run, first_err_code and first_err_cycle←cycle_count (pre-increment value) are latched.
  - cycle_count+1.
- Termination:
  - CHECK to DONE on the edge where cycle_count==WINDOW-1 (exactly WINDOW cycles checked).
  - With STOP_ON_ERR=1, also on the first mismatch edge; cycle_count still increments on that edge.
- DONE:
  - busy=0; pass/fail registered, mutually exclusive.
  - All results hold until start or clear.
- start while in CHECK is ignored.
- obs_* inputs are synchronous to clk by contract. Async flop reset is modelled via obs_rst_n level at the sampling edge. No assertions on X inputs.
- Latency: pass/fail valid one cycle after the final checked edge. All outputs registered.

Decomposition:
- Package ff_chk_pkg:
  - state enum {IDLE, CHECK, DONE}.
  - Error-code constants ERR_NONE=2'b00, ERR_Q=2'b01, ERR_QN=2'b10, ERR_BOTH=2'b11.
- Sub-module ff_ref_model: golden flop (exp_q/exp_vld with load/clear/enable). Instantiated once inside ff_resp_checker.

Test Plan:
- Correct flop, WINDOW=32, obs_rst_n low 1 cycle then high, obs_clk_en=1, obs_d toggling every 2 cycles → after 32 checked cycles pass=1, fail=0, err_count=0, cycle_count=32.
- Flop with q stuck at 0, obs_d=1 from checked cycle 3, obs_clk_en=1 → fail=1, first_err_code=01, first_err_cycle=4, err_count=28.
- obs_clk_en=0 for cycles 5–10 while obs_d toggles and q holds → no errors. Then feed obs_q following obs_d despite obs_clk_en=0 → first_err_code=01 at the first toggled cycle.
- obs_qn forced equal to obs_q at cycle 7 only → err_count=1, first_err_code=10, first_err_cycle=7, fail=1.
- STOP_ON_ERR=1, mismatch at cycle 2 → DONE after that edge, cycle_count=3, busy=0 next cycle, fail=1.
- rst_n pulsed low mid-run (cycle 10) → immediately IDLE, all outputs 0. start after release → fresh run, exp_vld=0 so the first q compare is skipped.
